// File: rtl/wb_pipe_unit.sv
// Writeback stage: latches one pipeline entry, extracts and extends load data,
// selects the writeback source and counts retired register writes.
module wb_pipe_unit #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_CNT  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_mem_data,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic [NB_DATA-1:0] i_pc_link,
   input  logic [1:0]         i_byte_off,
   input  logic [1:0]         i_load_size,
   input  logic               i_load_unsigned,
   input  logic [1:0]         i_wb_sel,
   input  logic [NB_ADDR-1:0] i_reg2write,
   input  logic               i_regWrite,
   input  logic               i_cnt_clear,
   output logic [NB_DATA-1:0] o_write_data,
   output logic [NB_ADDR-1:0] o_reg2write,
   output logic               o_regWrite,
   output logic [NB_CNT-1:0]  o_wb_count
);

   logic               valid_q;
   logic [NB_DATA-1:0] mem_q;
   logic [NB_DATA-1:0] alu_q;
   logic [NB_DATA-1:0] link_q;
   logic [1:0]         off_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [1:0]         sel_q;
   logic [NB_ADDR-1:0] rd_q;
   logic               we_q;
   logic [NB_CNT-1:0]  cnt_q;

   logic [7:0]         byte_val;
   logic [15:0]        half_val;
   logic [NB_DATA-1:0] load_data;
   logic               retire;

   // Flush only kills the entry; the other fields keep whatever they held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         mem_q   <= '0;
         alu_q   <= '0;
         link_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         sel_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
      end else if (i_flush) begin
         valid_q <= 1'b0;
      end else if (!i_stall) begin
         valid_q <= i_valid;
         mem_q   <= i_mem_data;
         alu_q   <= i_alu_result;
         link_q  <= i_pc_link;
         off_q   <= i_byte_off;
         size_q  <= i_load_size;
         uns_q   <= i_load_unsigned;
         sel_q   <= i_wb_sel;
         rd_q    <= i_reg2write;
         we_q    <= i_regWrite;
      end
   end

   always_comb begin
      byte_val = mem_q[7:0];
      case (off_q)
         2'd0:    byte_val = mem_q[7:0];
         2'd1:    byte_val = mem_q[15:8];
         2'd2:    byte_val = mem_q[23:16];
         default: byte_val = mem_q[31:24];
      endcase
      half_val = off_q[1] ? mem_q[31:16] : mem_q[15:0];
      case (size_q)
         2'b00:   load_data = {{(NB_DATA-8){byte_val[7] & ~uns_q}}, byte_val};
         2'b01:   load_data = {{(NB_DATA-16){half_val[15] & ~uns_q}}, half_val};
         default: load_data = mem_q;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'b01:   o_write_data = load_data;
         2'b10:   o_write_data = link_q;
         default: o_write_data = alu_q;
      endcase
   end

   assign o_reg2write = rd_q;
   assign o_regWrite  = valid_q & we_q & (rd_q != '0);
   assign o_wb_count  = cnt_q;

   // An entry retires only when it leaves the latch, so a stalled write counts once.
   assign retire = o_regWrite & (~i_stall | i_flush);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (i_cnt_clear) begin
         cnt_q <= '0;
      end else if (retire && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_pipe_unit.sv
// Scoreboard bench for wb_pipe_unit: directed entries push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_pipe_unit;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic [3:0]  cnt;
      logic        chk;
   } exp_t;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_stall;
   logic        i_flush;
   logic        i_valid;
   logic [31:0] i_mem_data;
   logic [31:0] i_alu_result;
   logic [31:0] i_pc_link;
   logic [1:0]  i_byte_off;
   logic [1:0]  i_load_size;
   logic        i_load_unsigned;
   logic [1:0]  i_wb_sel;
   logic [4:0]  i_reg2write;
   logic        i_regWrite;
   logic        i_cnt_clear;
   logic [31:0] o_write_data;
   logic [4:0]  o_reg2write;
   logic        o_regWrite;
   logic [3:0]  o_wb_count;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_data;
   logic [4:0]  m_rd;
   logic        m_we;
   logic [3:0]  m_cnt;
   logic        m_chk;

   wb_pipe_unit #(.NB_DATA(32), .NB_ADDR(5), .NB_CNT(4)) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_stall         (i_stall),
      .i_flush         (i_flush),
      .i_valid         (i_valid),
      .i_mem_data      (i_mem_data),
      .i_alu_result    (i_alu_result),
      .i_pc_link       (i_pc_link),
      .i_byte_off      (i_byte_off),
      .i_load_size     (i_load_size),
      .i_load_unsigned (i_load_unsigned),
      .i_wb_sel        (i_wb_sel),
      .i_reg2write     (i_reg2write),
      .i_regWrite      (i_regWrite),
      .i_cnt_clear     (i_cnt_clear),
      .o_write_data    (o_write_data),
      .o_reg2write     (o_reg2write),
      .o_regWrite      (o_regWrite),
      .o_wb_count      (o_wb_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every expectation pushed after an edge is compared at the following negedge.
   always @(negedge i_clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_output("regWrite", {31'd0, o_regWrite}, {31'd0, e.we});
         check_output("wb_count", {28'd0, o_wb_count}, {28'd0, e.cnt});
         if (e.chk) begin
            check_output("write_data", o_write_data, e.data);
            check_output("reg2write", {27'd0, o_reg2write}, {27'd0, e.rd});
         end
      end
   end

   // One rising edge: update the reference state from the current inputs and queue the expectation.
   task automatic tick(input logic [31:0] exp_data);
      logic ret;
      exp_t e;
      ret = m_we && (!i_stall || i_flush);
      @(posedge i_clk);
      #1;
      if (i_cnt_clear) m_cnt = 4'd0;
      else if (ret && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      if (i_flush) begin
         m_we  = 1'b0;
         m_chk = 1'b0;
      end else if (!i_stall) begin
         m_we   = i_valid && i_regWrite && (i_reg2write != 5'd0);
         m_data = exp_data;
         m_rd   = i_reg2write;
         m_chk  = 1'b1;
      end
      e.data = m_data;
      e.rd   = m_rd;
      e.we   = m_we;
      e.cnt  = m_cnt;
      e.chk  = m_chk;
      sb.push_back(e);
   endtask

   task automatic apply_stimulus(input logic [1:0] sel, input logic [1:0] size, input logic [1:0] off,
                                 input logic uns, input logic [31:0] mem, input logic [31:0] alu,
                                 input logic [31:0] link, input logic [4:0] rd, input logic we,
                                 input logic [31:0] exp_data);
      i_stall         = 1'b0;
      i_flush         = 1'b0;
      i_valid         = 1'b1;
      i_wb_sel        = sel;
      i_load_size     = size;
      i_byte_off      = off;
      i_load_unsigned = uns;
      i_mem_data      = mem;
      i_alu_result    = alu;
      i_pc_link       = link;
      i_reg2write     = rd;
      i_regWrite      = we;
      tick(exp_data);
   endtask

   task automatic model_reset();
      m_data = 32'd0;
      m_rd   = 5'd0;
      m_we   = 1'b0;
      m_cnt  = 4'd0;
      m_chk  = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_cnt_clear = 1'b0;
      i_mem_data = 32'd0; i_alu_result = 32'd0; i_pc_link = 32'd0;
      i_byte_off = 2'd0; i_load_size = 2'd0; i_load_unsigned = 1'b0;
      i_wb_sel = 2'd0; i_reg2write = 5'd0; i_regWrite = 1'b0;
      model_reset();

      #12;
      check_output("rst_regWrite", {31'd0, o_regWrite}, 32'd0);
      check_output("rst_count", {28'd0, o_wb_count}, 32'd0);
      check_output("rst_data", o_write_data, 32'd0);
      check_output("rst_rd", {27'd0, o_reg2write}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Byte and half loads
      apply_stimulus(2'b01, 2'b00, 2'd0, 1'b0, 32'h8000_7F80, 32'h0, 32'h0, 5'd1, 1'b1, 32'hFFFF_FF80);
      apply_stimulus(2'b01, 2'b00, 2'd0, 1'b1, 32'h8000_7F80, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0000_0080);
      apply_stimulus(2'b01, 2'b00, 2'd1, 1'b0, 32'h8000_7F80, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_007F);
      apply_stimulus(2'b01, 2'b00, 2'd3, 1'b0, 32'h8000_7F80, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFF_FF80);
      apply_stimulus(2'b01, 2'b00, 2'd2, 1'b1, 32'h8000_7F80, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_0000);
      apply_stimulus(2'b01, 2'b01, 2'd2, 1'b0, 32'h8001_1234, 32'h0, 32'h0, 5'd6, 1'b1, 32'hFFFF_8001);
      apply_stimulus(2'b01, 2'b01, 2'd3, 1'b0, 32'h8001_1234, 32'h0, 32'h0, 5'd7, 1'b1, 32'hFFFF_8001);
      apply_stimulus(2'b01, 2'b01, 2'd0, 1'b1, 32'h8001_1234, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0000_1234);
      apply_stimulus(2'b01, 2'b01, 2'd1, 1'b0, 32'h0000_8ABC, 32'h0, 32'h0, 5'd8, 1'b1, 32'hFFFF_8ABC);
      // Word loads and source select
      apply_stimulus(2'b01, 2'b10, 2'd3, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd9, 1'b1, 32'hDEAD_BEEF);
      apply_stimulus(2'b01, 2'b11, 2'd1, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd10, 1'b1, 32'hCAFE_F00D);
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 5'd11, 1'b1, 32'h1234_5678);
      apply_stimulus(2'b11, 2'b00, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'hA5A5_0001, 32'h44, 5'd12, 1'b1, 32'hA5A5_0001);
      apply_stimulus(2'b10, 2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0000_0108, 5'd31, 1'b1, 32'h0000_0108);
      apply_stimulus(2'b10, 2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0000_0108, 5'd0, 1'b1, 32'h0000_0108);
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h77, 32'h0, 5'd13, 1'b0, 32'h0000_0077);
      i_valid = 1'b0;
      i_stall = 1'b0;
      i_flush = 1'b0;
      i_regWrite = 1'b1;
      i_reg2write = 5'd14;
      i_alu_result = 32'h99;
      i_wb_sel = 2'b00;
      tick(32'h0000_0099);

      // Stall: held entry stays on the outputs and retires once on release
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h55, 32'h0, 5'd3, 1'b1, 32'h0000_0055);
      i_stall = 1'b1;
      i_alu_result = 32'hBAD0_BAD0;
      i_reg2write = 5'd7;
      repeat (3) tick(32'hBAD0_BAD0);
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h66, 32'h0, 5'd4, 1'b1, 32'h0000_0066);
      // Flush wins over stall in the same cycle
      i_stall = 1'b1;
      i_flush = 1'b1;
      tick(32'h0);
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h21, 32'h0, 5'd5, 1'b1, 32'h0000_0021);

      // Saturation of the 4-bit counter and clear priority over a retire
      i_cnt_clear = 1'b1;
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0000_0100);
      i_cnt_clear = 1'b0;
      for (int k = 0; k < 20; k++)
         apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'(k), 32'h0, 5'd2, 1'b1, 32'(k));
      i_cnt_clear = 1'b1;
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h200, 32'h0, 5'd6, 1'b1, 32'h0000_0200);
      i_cnt_clear = 1'b0;
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h300, 32'h0, 5'd9, 1'b1, 32'h0000_0300);

      // Asynchronous reset between edges while an entry is held by stall
      i_stall = 1'b1;
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_output("async_regWrite", {31'd0, o_regWrite}, 32'd0);
      check_output("async_count", {28'd0, o_wb_count}, 32'd0);
      check_output("async_data", o_write_data, 32'd0);
      check_output("async_rd", {27'd0, o_reg2write}, 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      model_reset();
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h400, 32'h0, 5'd10, 1'b1, 32'h0000_0400);
      apply_stimulus(2'b00, 2'b00, 2'd0, 1'b0, 32'h0, 32'h500, 32'h0, 5'd11, 1'b1, 32'h0000_0500);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge i_clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
